imem_loader: RTL and testbench

Boot-time instruction memory loader for the Mig1 CPU. Accepts a byte stream on a valid/ready port, assembles little-endian 32-bit words and writes them sequentially into the instruction RAM, starting at byte address 0. It is the write-side counterpart of the CPU fetch port. It holds the CPU in reset until the image is fully written.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 37 +++
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Stream framing: 16-bit word count, then little-endian 32-bit words.
package imem_loader_pkg;

    localparam int LEN_WIDTH      = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects stream bytes into little-endian 32-bit words.
// Only 3 bytes are stored; the 4th is forwarded straight into word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] asm_q;
    logic        last;

    assign last       = (cnt == 2'(BYTES_PER_WORD - 1));
    assign word_valid = take && last;
    assign word       = {data, asm_q};

    // Newer bytes enter at the top so the first byte ends up in [7:0].
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt   <= 2'd0;
            asm_q <= 24'd0;
        end else if (take) begin
            if (last) begin
                cnt <= 2'd0;
            end else begin
                cnt   <= cnt + 2'd1;
                asm_q <= {data, asm_q[23:8]};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes a length-prefixed byte stream into instruction RAM
// and holds the CPU in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       we,
    output logic [IMEM_ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       cpu_reset,
    output logic                       done,
    output logic                       error
);

    localparam int IDX_W = IMEM_ADDR_WIDTH - 1;
    localparam logic [LEN_WIDTH:0] DEPTH =
        (LEN_WIDTH + 1)'(2 ** (IMEM_ADDR_WIDTH - 2));

    state_t               state;
    state_t               state_n;
    logic [7:0]           len_lo;
    logic [LEN_WIDTH-1:0] n_q;
    logic [LEN_WIDTH-1:0] len_full;
    logic [IDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]     idx_next;
    logic                 take;
    logic                 pk_take;
    logic                 word_valid;
    logic [31:0]          word;
    logic                 last_word;

    assign in_ready  = !reset && is_loading(state);
    assign take      = in_valid && in_ready;
    assign pk_take   = take && (state == S_DATA);
    assign len_full  = {in_data, len_lo};
    assign idx_next  = word_idx + IDX_W'(1);
    assign last_word = (LEN_WIDTH'(idx_next) == n_q);

    assign cpu_reset = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

    byte_packer u_packer (
        .clk        (clk),
        .clear      (reset),
        .take       (pk_take),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_LEN_LO: begin
                if (take) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (take) begin
                    if (len_full == '0)
                        state_n = S_DONE;
                    else if ({1'b0, len_full} > DEPTH)
                        state_n = S_ERROR;
                    else
                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid && last_word) state_n = S_DONE;
            end
            S_DONE:  state_n = S_DONE;
            S_ERROR: state_n = S_ERROR;
            default: state_n = S_LEN_LO;
        endcase
    end

    // Write port registers; wdata is independent of the packer so the
    // next word can start assembling while this one is being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            word_idx <= '0;
            len_lo   <= 8'd0;
            n_q      <= '0;
        end else begin
            we <= word_valid;
            if (word_valid) begin
                wdata    <= DATA_WIDTH'(word);
                waddr    <= {word_idx[IMEM_ADDR_WIDTH-3:0], 2'b00};
                word_idx <= idx_next;
            end
            if (take && state == S_LEN_LO) len_lo <= in_data;
            if (take && state == S_LEN_HI) n_q <= len_full;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream model.
// The model derives the expected write list directly from the byte stream.
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 2 ** (AW - 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sq[$];
    logic [39:0] exp_q[$];
    bit          exp_err;

    logic [39:0] wq[$];
    bit          wdone_q[$];
    bit          wcr_q[$];
    int          run = 0;
    int          run_max = 0;

    imem_loader #(.IMEM_ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wq.push_back({waddr, wdata});
            wdone_q.push_back(done);
            wcr_q.push_back(cpu_reset);
            run = run + 1;
            if (run > run_max) run_max = run;
        end else begin
            run = 0;
        end
    end

    function automatic void build(input int n);
        int nb;
        sq.delete();
        sq.push_back(n[7:0]);
        sq.push_back(n[15:8]);
        nb = (n <= DEPTH) ? 4 * n : 8;
        for (int i = 0; i < nb; i++) sq.push_back(8'($urandom));
    endfunction

    function automatic void model();
        int n;
        n = int'({sq[1], sq[0]});
        exp_q.delete();
        exp_err = (n > DEPTH);
        if (!exp_err)
            for (int i = 0; i < n; i++)
                exp_q.push_back({8'(i * 4), sq[4*i+5], sq[4*i+4],
                                 sq[4*i+3], sq[4*i+2]});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        wdone_q.delete();
        wcr_q.delete();
        run_max = 0;
        reset = 1'b0;
    endtask

    task automatic push_bytes(input int idle_pct);
        foreach (sq[i]) begin
            for (int k = 0; k < 5 && $urandom_range(99) < idle_pct; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = sq[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_terminal(input string name);
        int t = 0;
        while (t < 40 && !(done === 1'b1 || error === 1'b1)) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL %s timeout: done=%b error=%b required terminal",
                     name, done, error);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, we, cpu_reset, done, error} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00100",
                     {in_ready, we, cpu_reset, done, error});
        end
        n_checks++;
        if ({waddr, wdata} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_wport: got %h required 0", {waddr, wdata});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        do_reset();
        sq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_bytes(0);
        wait_terminal("directed");
        n_checks++;
        if (wq.size() !== 2) begin
            n_fail++;
            $display("FAIL directed_count: got %0d required 2", wq.size());
        end else begin
            n_checks++;
            if (wq[0] !== {8'h00, 32'h00000013}) begin
                n_fail++;
                $display("FAIL directed_w0: got %h required 0000000013", wq[0]);
            end
            n_checks++;
            if (wq[1] !== {8'h04, 32'hDEADBEEF}) begin
                n_fail++;
                $display("FAIL directed_w1: got %h required 04deadbeef", wq[1]);
            end
            n_checks++;
            if ({wdone_q[0], wcr_q[0], wdone_q[1], wcr_q[1]} !== 4'b0110) begin
                n_fail++;
                $display("FAIL directed_done_timing: got %b required 0110",
                         {wdone_q[0], wcr_q[0], wdone_q[1], wcr_q[1]});
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_ready_after: got %b required 0", in_ready);
        end
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wq.size() !== 2 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL directed_extra: writes %0d done %b required 2 1",
                     wq.size(), done);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_early_done: got %b required 0", done);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({done, cpu_reset, in_ready, error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL zero_done: got %b required 1000",
                     {done, cpu_reset, in_ready, error});
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (wq.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_no_we: got %0d writes required 0", wq.size());
        end
    endtask

    task automatic test_load(input string name, input int n, input int idle);
        do_reset();
        build(n);
        model();
        push_bytes(idle);
        wait_terminal(name);
        n_checks++;
        if (wq.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d required %0d",
                     name, wq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s write%0d: got %h required %h",
                         name, i, wq[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({done, error, cpu_reset, in_ready} !==
            {!exp_err, exp_err, exp_err, 1'b0}) begin
            n_fail++;
            $display("FAIL %s status: got %b required %b", name,
                     {done, error, cpu_reset, in_ready},
                     {!exp_err, exp_err, exp_err, 1'b0});
        end
        if (exp_q.size() > 0 && wq.size() == exp_q.size()) begin
            n_checks++;
            if ({wdone_q[wq.size()-1], run_max} !== {1'b1, 32'd1}) begin
                n_fail++;
                $display("FAIL %s last_we: done %b run %0d required 1 1",
                         name, wdone_q[wq.size()-1], run_max);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sq = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        push_bytes(0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_reset, in_ready, we} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_flags: got %b required 100",
                     {cpu_reset, in_ready, we});
        end
        reset = 1'b0;
        sq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        push_bytes(0);
        wait_terminal("midreset");
        n_checks++;
        if (wq.size() !== 1) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d required 1", wq.size());
        end else begin
            n_checks++;
            if (wq[0] !== {8'h00, 32'h11223344}) begin
                n_fail++;
                $display("FAIL midreset_word: got %h required 0011223344",
                         wq[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_len();
        test_load("full", DEPTH, 0);
        test_load("overflow", DEPTH + 1, 0);
        test_load("overflow_big", int'($urandom_range(65535, DEPTH + 2)), 0);
        test_load("gaps", 3, 30);
        test_load("gaps_rand", int'($urandom_range(DEPTH, 1)), 30);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
